// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcode encodings, the eight
// instruction phases and the ALU-operand membership test.
package cpu_defs;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    // Instructions that read a memory operand into the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

    // Phases wrap STORE -> INST_ADDR through 3-bit modulo arithmetic.
    function automatic phase_e next_phase(input phase_e p);
        logic [2:0] raw;
        raw = p + 3'd1;
        return phase_e'(raw);
    endfunction

endpackage

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer: a phase counter plus a sticky halt flag,
// with all datapath strobes decoded combinationally from them and the opcode.
module cpu_controller
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // A HLT caught in OP_ADDR parks the phase there; only reset releases it.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && opcode == HLT) begin
                halted_d = 1'b1;
            end else begin
                phase_d = next_phase(phase_q);
            end
        end
    end

    assign aluop = is_aluop(opcode);
    assign phase = phase_q;

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            unique case (phase_q)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    rd = aluop;
                end
                ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == SKZ) && zero;
                    ld_pc  = (opcode == JMP);
                    data_e = (opcode == STO);
                end
                STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == JMP);
                    wr     = (opcode == STO);
                    data_e = (opcode == STO);
                end
                default: begin
                    sel = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: a phase/halt reference model, a
// behavioural program counter downstream of the strobes, and randomized opcodes.
module tb_cpu_controller;

    logic       clk;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [2:0] phase;
    logic [11:0] obs;

    logic [4:0] ir_addr;
    logic [4:0] pc;

    int checks = 0;
    int errors = 0;
    int m_phase = 0;
    bit m_halted = 1'b0;

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    assign obs = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream program counter: load has priority over increment.
    always @(posedge clk) begin
        if (!rst)        pc <= 5'd0;
        else if (ld_pc)  pc <= ir_addr;
        else if (inc_pc) pc <= pc + 5'd1;
    end

    // Expected strobe vector {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt,phase}.
    function automatic logic [11:0] exp_out(input int p, input bit h,
                                            input logic [2:0] op, input logic z);
        logic s = 0, r = 0, w = 0, li = 0, la = 0, lp = 0, ip = 0, de = 0, hl = 0;
        bit alu;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        if (h) return {9'b0_0000_0001, 3'd4};
        if (p <= 3) begin
            s  = 1'b1;
            r  = (p >= 1);
            li = (p >= 2);
        end else if (p == 4) begin
            ip = 1'b1;
            hl = (op == 3'd0);
        end else begin
            r  = alu;
            ip = (p == 6) && (op == 3'd1) && z;
            lp = (p >= 6) && (op == 3'd7);
            de = (p >= 6) && (op == 3'd6);
            w  = (p == 7) && (op == 3'd6);
            la = (p == 7) && alu;
        end
        return {s, r, w, li, la, lp, ip, de, hl, 3'(p)};
    endfunction

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        int np;
        bit nh;
        if (!rst) begin
            np = 0; nh = 1'b0;
        end else if (m_halted) begin
            np = m_phase; nh = 1'b1;
        end else if (m_phase == 4 && opcode == 3'd0) begin
            np = 4; nh = 1'b1;
        end else begin
            np = (m_phase + 1) % 8; nh = 1'b0;
        end
        @(posedge clk);
        #1;
        m_phase  = np;
        m_halted = nh;
    endtask

    task automatic go_phase0();
        for (int k = 0; k < 8 && m_phase != 0; k++) begin
            opcode = 3'd2;
            zero   = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        opcode = 3'($urandom_range(0, 7));
        zero = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 8'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, {1'b1, 8'b0, 3'd0});
        end
    endtask

    task automatic test_reset_mid();
        go_phase0();
        for (int k = 0; k < 5; k++) begin
            opcode = 3'd2;
            tick();
        end
        #1;
        checks++;
        if (phase !== 3'd5) begin
            errors++;
            $display("FAIL reset_mid_setup: got phase %0d expected 5", phase);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== {1'b1, 8'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b expected %b", obs, {1'b1, 8'b0, 3'd0});
        end
        for (int i = 0; i < 9; i++) begin
            opcode = 3'($urandom_range(1, 7));
            #1;
            checks++;
            if (phase !== 3'(i % 8)) begin
                errors++;
                $display("FAIL reset_mid_sequence: step %0d got phase %0d expected %0d", i, phase, i % 8);
            end
            tick();
        end
    endtask

    task automatic test_lda();
        logic [4:0] want;
        go_phase0();
        for (int i = 0; i < 8; i++) begin
            opcode = (i < 4) ? 3'($urandom_range(0, 7)) : 3'd5;
            zero   = 1'($urandom_range(0, 1));
            #1;
            want = {1'(i inside {1, 2, 3, 5, 6, 7}), 1'(i inside {2, 3}), 1'(i == 4), 1'(i == 7), 1'b0};
            checks++;
            if ({rd, ld_ir, inc_pc, ld_ac, wr} !== want) begin
                errors++;
                $display("FAIL lda_strobes: phase %0d got %b expected %b", i, {rd, ld_ir, inc_pc, ld_ac, wr}, want);
            end
            checks++;
            if (obs !== exp_out(m_phase, m_halted, opcode, zero)) begin
                errors++;
                $display("FAIL lda_model: phase %0d got %b expected %b", i, obs, exp_out(m_phase, m_halted, opcode, zero));
            end
            tick();
        end
    endtask

    task automatic test_sto();
        logic [2:0] want;
        go_phase0();
        for (int i = 0; i < 8; i++) begin
            opcode = (i < 4) ? 3'($urandom_range(0, 7)) : 3'd6;
            zero   = 1'($urandom_range(0, 1));
            #1;
            want = {1'(i >= 6), 1'(i == 7), 1'(i inside {1, 2, 3})};
            checks++;
            if ({data_e, wr, rd} !== want) begin
                errors++;
                $display("FAIL sto_strobes: phase %0d got %b expected %b", i, {data_e, wr, rd}, want);
            end
            tick();
        end
    endtask

    task automatic test_skz();
        logic [4:0] pc_start;
        for (int z = 1; z >= 0; z--) begin
            go_phase0();
            pc_start = pc;
            for (int i = 0; i < 8; i++) begin
                opcode = (i < 4) ? 3'($urandom_range(0, 7)) : 3'd1;
                // zero is wiggled outside ALU_OP to show it is ignored there
                zero   = (i == 6) ? 1'(z) : 1'($urandom_range(0, 1));
                #1;
                checks++;
                if (inc_pc !== ((i == 4) || (i == 6 && z == 1))) begin
                    errors++;
                    $display("FAIL skz_inc_pc: zero %0d phase %0d got %b", z, i, inc_pc);
                end
                tick();
            end
            checks++;
            if (pc !== 5'(pc_start + ((z == 1) ? 5'd2 : 5'd1))) begin
                errors++;
                $display("FAIL skz_pc_advance: zero %0d got %0d expected %0d", z, pc,
                         5'(pc_start + ((z == 1) ? 5'd2 : 5'd1)));
            end
        end
    endtask

    task automatic test_jmp();
        ir_addr = 5'b10101;
        go_phase0();
        for (int i = 0; i < 8; i++) begin
            opcode = (i < 4) ? 3'($urandom_range(0, 7)) : 3'd7;
            zero   = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({ld_pc, inc_pc} !== {1'(i >= 6), 1'(i == 4)}) begin
                errors++;
                $display("FAIL jmp_strobes: phase %0d got %b expected %b", i, {ld_pc, inc_pc}, {1'(i >= 6), 1'(i == 4)});
            end
            tick();
        end
        #1;
        checks++;
        if (pc !== 5'b10101 || phase !== 3'd0) begin
            errors++;
            $display("FAIL jmp_target: got pc %b phase %0d expected pc 10101 phase 0", pc, phase);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 320; n++) begin
            opcode = 3'($urandom_range(1, 7));
            zero   = 1'($urandom_range(0, 1));
            ir_addr = 5'($urandom);
            #1;
            checks++;
            if (obs !== exp_out(m_phase, m_halted, opcode, zero)) begin
                errors++;
                $display("FAIL random_model: op %0d zero %b got %b expected %b", opcode, zero, obs,
                         exp_out(m_phase, m_halted, opcode, zero));
            end
            checks++;
            if (ld_pc && inc_pc) begin
                errors++;
                $display("FAIL random_pc_exclusive: phase %0d got ld_pc=1 inc_pc=1 expected not both", phase);
            end
            tick();
        end
    endtask

    task automatic test_hlt();
        go_phase0();
        for (int i = 0; i < 5; i++) begin
            opcode = (i < 4) ? 3'($urandom_range(0, 7)) : 3'd0;
            zero   = 1'($urandom_range(0, 1));
            #1;
            if (i == 4) begin
                checks++;
                if ({halt, inc_pc, phase} !== {2'b11, 3'd4}) begin
                    errors++;
                    $display("FAIL hlt_entry: got %b expected %b", {halt, inc_pc, phase}, {2'b11, 3'd4});
                end
            end
            tick();
        end
        for (int k = 0; k < 24; k++) begin
            opcode = 3'($urandom_range(0, 7));
            zero   = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== {9'b0_0000_0001, 3'd4}) begin
                errors++;
                $display("FAIL hlt_frozen: clock %0d got %b expected %b", k, obs, {9'b0_0000_0001, 3'd4});
            end
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        opcode = 3'd0;
        #1;
        checks++;
        if (obs !== {1'b1, 8'b0, 3'd0}) begin
            errors++;
            $display("FAIL hlt_reset_release: got %b expected %b", obs, {1'b1, 8'b0, 3'd0});
        end
    endtask

    initial begin
        rst     = 1'b0;
        opcode  = 3'd0;
        zero    = 1'b0;
        ir_addr = 5'd0;
        test_reset();
        test_reset_mid();
        test_lda();
        test_sto();
        test_skz();
        test_jmp();
        test_random();
        test_hlt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Eight-phase instruction-sequencing FSM for the 8-bit RISC CPU. Steps through fetch/decode/execute every 8 clocks and drives all datapath control strobes: `sel` for the address mux, memory `rd`/`wr`, `ld_ir`, `ld_ac`, `data_e`, and the `ld_pc`/`inc_pc` inputs of `program_counter`. It sits directly upstream of `program_counter` and the memory/accumulator datapath, and consumes the opcode from the instruction register and the ALU zero flag.

## Interface
- `clk` in 1: system clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset), sampled on rising `clk`.
- `opcode` in 3: instruction opcode from IR (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7).
- `zero` in 1: accumulator-zero flag.
- `sel` out 1: address mux select (1 = PC address, 0 = IR operand address).
- `rd` out 1: memory read enable.
- `wr` out 1: memory write strobe.
- `ld_ir` out 1: load instruction register.
- `ld_ac` out 1: load accumulator.
- `ld_pc` out 1: load PC from IR address (to `program_counter.ld_pc`).
- `inc_pc` out 1: increment PC (to `program_counter.inc_pc`).
- `data_e` out 1: drive accumulator onto data bus.
- `halt` out 1: CPU halted / halting.
- `phase` out 3: current phase, for debug.

## Operation
- Phases, in fixed order, advancing by one every clock: INST_ADDR(0) → INST_FETCH(1) → INST_LOAD(2) → IDLE(3) → OP_ADDR(4) → OP_FETCH(5) → ALU_OP(6) → STORE(7) → INST_ADDR.
- ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Output decode per phase (unlisted outputs are 0):
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc; halt = (opcode==HLT).
  - OP_FETCH: rd = ALUOP.
  - ALU_OP: rd = ALUOP; inc_pc = (opcode==SKZ && zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - STORE: rd = ALUOP; ld_ac = ALUOP; ld_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- Outputs in phases 0–3 never depend on `opcode`. A stale opcode during fetch has no effect.
- `ld_pc` and `inc_pc` are never both 1 in the same cycle.
- Halt:
  - In OP_ADDR with opcode==HLT, `halt`=1 and `inc_pc`=1, so the PC moves past the HLT.
  - The sticky `halted` flag sets at the end of that cycle.
  - While `halted`=1: `phase` is frozen at OP_ADDR, `halt`=1, and every other strobe is 0.
  - Only reset clears `halted`.

## Timing
- Reset, checked at the rising edge with `rst`=0:
  - phase ← INST_ADDR and halted ← 0.
  - In the following cycle the outputs are sel=1, all others 0, halt=0, phase=0.
  - This overrides any phase, including mid-instruction and while halted.
- Outputs are combinational decodes of the registered phase/halted plus the current `opcode`/`zero`. No added latency.
- The PC and IR see a strobe at the rising edge that ends the phase in which it is asserted.
- One instruction takes exactly 8 clocks.
- SKZ with zero=1: the PC increments twice per instruction, in OP_ADDR and ALU_OP.
- JMP: `ld_pc` is high for 2 clocks (ALU_OP, STORE). The reload is idempotent.
- `zero` is sampled only in ALU_OP.
- After `phase` wraps from 7 to 0, it increments modulo 8.

## Structure
- Shared `cpu_defs` package/include holds:
  - opcode constants HLT…JMP (3-bit);
  - phase constants INST_ADDR…STORE (3-bit);
  - the ALUOP membership function.
- These are used by this block, the ALU and the IR.
- Single module: a 3-bit phase register, a halted flag, and a combinational output decode. No sub-module.

## Test plan
- Reset mid-operation:
  - Stimulus: hold `rst`=0 for 1 clock while at phase 5.
  - Required: phase=0 next cycle, sel=1, all other strobes 0.
  - Required: with `rst`=1, phase then steps 0,1,…,7,0 on successive clocks.
- LDA (opcode=5):
  - rd=1 in phases 1–3 and 5–7.
  - ld_ir=1 in phases 2–3.
  - inc_pc=1 only in phase 4.
  - ld_ac=1 only in phase 7.
  - wr=0 throughout.
- STO (opcode=6):
  - data_e=1 in phases 6–7.
  - wr=1 only in phase 7.
  - rd=0 in phases 5–7.
- SKZ (opcode=1):
  - With zero=1: inc_pc=1 in phases 4 and 6, and a connected `program_counter` advances by 2 per instruction.
  - With zero=0: inc_pc=1 only in phase 4.
- JMP (opcode=7):
  - ld_pc=1 in phases 6–7, and inc_pc=0 in both.
  - A connected `program_counter` with ir_addr=5'b10101 reads 10101 at the next phase 0.
- HLT (opcode=0):
  - halt=1 and inc_pc=1 in phase 4.
  - Afterwards, phase stays at 4, halt=1, and all other strobes are 0 for at least 20 clocks.
  - Asserting `rst`=0 for 1 clock restores phase=0 and halt=0.
